// File: rtl/des_dec_key_schedule.sv
// DES key schedule producing round keys in decryption order (K16 .. K1),
// one per valid/ready handshake. Optional per-byte odd-parity check on the
// loaded key is enabled by defining DES_KS_PARITY_CHECK_EN.

module des_dec_key_schedule (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        key_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_idx,
    output logic        key_valid,
    output logic        busy,
    output logic        done
`ifdef DES_KS_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    // Handshake: a key transfers on a rising edge where key_valid && key_ready;
    // round_key/round_idx stay stable while key_valid is high and key_ready low.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // Tables use DES 1-based bit numbering; DES bit n of a w-bit word is [w-n].
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47 - i] = cd[56 - PC2[i]];
        end
        return r;
    endfunction

    // Right rotation undoes the encryption-order left shift; DES bit 1 is the MSB.
    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic by_two);
        logic [27:0] r;
        if (by_two) begin
            r = {v[1:0], v[27:2]};
        end else begin
            r = {v[0], v[27:1]};
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        shift_two;

    // Shift of round (idx+1) is 1 for rounds 1, 2, 9 and 16, otherwise 2.
    always_comb begin
        shift_two = 1'b1;
        case (idx_q)
            4'd0, 4'd1, 4'd8, 4'd15: shift_two = 1'b0;
            default:                 shift_two = 1'b1;
        endcase
    end

`ifdef DES_KS_PARITY_CHECK_EN
    logic parity_err_q, parity_err_d;
    logic key_par_ok;

    always_comb begin
        key_par_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            key_par_ok = key_par_ok & (^key_in[8*b +: 8]);
        end
    end

    assign parity_err = parity_err_q;
`else
    // PC-1 discards the parity bits, so they have no reader in this build.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                  key_in[24], key_in[16], key_in[8],  key_in[0]};
`endif

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DES_KS_PARITY_CHECK_EN
                    if (!key_par_ok) begin
                        parity_err_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b0;
                        cd_d         = pc1_perm(key_in);
                        idx_d        = 4'd15;
                        state_d      = S_EMIT;
                    end
`else
                    // Sixteen left shifts total 28, so C16D16 equals C0D0.
                    cd_d    = pc1_perm(key_in);
                    idx_d   = 4'd15;
                    state_d = S_EMIT;
`endif
                end
            end
            S_EMIT: begin
                if (key_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cd_d  = {rotr28(cd_q[55:28], shift_two),
                                 rotr28(cd_q[27:0],  shift_two)};
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cd_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef DES_KS_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef DES_KS_PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign key_valid = (state_q == S_EMIT);
    assign busy      = (state_q == S_EMIT);
    assign done      = done_q;
    assign round_idx = idx_q;
    assign round_key = pc2_perm(cd_q);

endmodule

// File: tb/tb_des_dec_key_schedule.sv
// Directed bench for des_dec_key_schedule using the classic DES example key
// 0x133457799BBCDFF1 and its published round keys K1..K16.

module tb_des_dec_key_schedule;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_ready = 1'b0;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        key_valid;
    logic        busy;
    logic        done;
`ifdef DES_KS_PARITY_CHECK_EN
    logic        parity_err;
`endif

    des_dec_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
`ifdef DES_KS_PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    // k_tab[r] is K(r+1) for KEY_A.
    logic [47:0] k_tab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [47:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [63:0] k);
        start  = 1'b1;
        key_in = k;
        step();
        start  = 1'b0;
        key_in = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
        repeat (3) step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            key_ready = (c >= 2);
            step();
            n_checks++;
            if ({key_valid, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags c%0d: got %b expected 000", c, {key_valid, busy, done});
            end
            n_checks++;
            if (round_idx !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idx c%0d: got %0d expected 0", c, round_idx);
            end
            n_checks++;
            if (round_key !== 48'd0) begin
                n_fail++;
                $display("FAIL reset_key c%0d: got %h expected 0", c, round_key);
            end
`ifdef DES_KS_PARITY_CHECK_EN
            n_checks++;
            if (parity_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_parity c%0d: got %b expected 0", c, parity_err);
            end
`endif
        end
    endtask

    task automatic test_ready_high();
        logic [47:0] exp;
        exp_q.delete();
        for (int r = 15; r >= 0; r--) exp_q.push_back(k_tab[r]);
        key_ready = 1'b1;
        issue_start(KEY_A);
        for (int i = 0; i < 16; i++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (key_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL high_flags i%0d: got v%b b%b d%b expected v1 b1 d0", i, key_valid, busy, done);
            end
            n_checks++;
            if (round_idx !== 4'(15 - i)) begin
                n_fail++;
                $display("FAIL high_idx i%0d: got %0d expected %0d", i, round_idx, 15 - i);
            end
            n_checks++;
            if (round_key !== exp) begin
                n_fail++;
                $display("FAIL high_key i%0d: got %h expected %h", i, round_key, exp);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL high_done: got d%b b%b v%b expected d1 b0 v0", done, busy, key_valid);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL high_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_ready_toggle();
        logic [47:0] exp;
        exp_q.delete();
        for (int r = 15; r >= 0; r--) exp_q.push_back(k_tab[r]);
        key_ready = 1'b0;
        issue_start(KEY_A);
        for (int i = 0; i < 16; i++) begin
            exp = exp_q.pop_front();
            key_ready = 1'b0;
            n_checks++;
            if (round_idx !== 4'(15 - i) || round_key !== exp || key_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL toggle_key i%0d: got v%b idx %0d key %h expected v1 idx %0d key %h",
                         i, key_valid, round_idx, round_key, 15 - i, exp);
            end
            step();
            n_checks++;
            if (round_idx !== 4'(15 - i) || round_key !== exp || key_valid !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle_hold i%0d: got v%b d%b idx %0d key %h expected v1 d0 idx %0d key %h",
                         i, key_valid, done, round_idx, round_key, 15 - i, exp);
            end
            key_ready = 1'b1;
            step();
        end
        n_checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_done: got d%b v%b expected d1 v0", done, key_valid);
        end
        key_ready = 1'b0;
        step();
    endtask

    task automatic test_start_ignored();
        key_ready = 1'b1;
        issue_start(KEY_A);
        for (int i = 0; i < 16; i++) begin
            start  = (i == 5);
            key_in = (i == 5) ? KEY_B : '0;
            n_checks++;
            if (round_idx !== 4'(15 - i) || round_key !== k_tab[15 - i]) begin
                n_fail++;
                $display("FAIL ignore_key i%0d: got idx %0d key %h expected idx %0d key %h",
                         i, round_idx, round_key, 15 - i, k_tab[15 - i]);
            end
            step();
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_done: got %b expected 1", done);
        end
        step();
    endtask

    task automatic test_start_on_last();
        key_ready = 1'b1;
        issue_start(KEY_A);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                start  = 1'b1;
                key_in = KEY_A;
            end
            step();
        end
        n_checks++;
        if (key_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL last_start_ignored: got v%b d%b expected v0 d1", key_valid, done);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (key_valid !== 1'b1 || round_idx !== 4'd15 || round_key !== k_tab[15] || done !== 1'b0) begin
            n_fail++;
            $display("FAIL last_start_taken: got v%b d%b idx %0d key %h expected v1 d0 idx 15 key %h",
                     key_valid, done, round_idx, round_key, k_tab[15]);
        end
        repeat (16) step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL last_drain_done: got %b expected 1", done);
        end
        step();
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b1;
        issue_start(KEY_A);
        repeat (7) step();
        n_checks++;
        if (round_idx !== 4'd8 || round_key !== k_tab[8]) begin
            n_fail++;
            $display("FAIL mid_pre: got idx %0d key %h expected idx 8 key %h", round_idx, round_key, k_tab[8]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd0 || round_key !== 48'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v%b b%b d%b idx %0d key %h expected all zero",
                     key_valid, busy, done, round_idx, round_key);
        end
        issue_start(KEY_A);
        n_checks++;
        if (key_valid !== 1'b1 || round_idx !== 4'd15 || round_key !== k_tab[15]) begin
            n_fail++;
            $display("FAIL mid_restart: got v%b idx %0d key %h expected v1 idx 15 key %h",
                     key_valid, round_idx, round_key, k_tab[15]);
        end
        repeat (16) step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_done: got %b expected 1", done);
        end
        step();
    endtask

`ifdef DES_KS_PARITY_CHECK_EN
    task automatic test_parity();
        key_ready = 1'b1;
        issue_start(64'h133457799BBCDFF0);
        n_checks++;
        if (parity_err !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad: got perr %b v%b expected perr 1 v0", parity_err, key_valid);
        end
        step();
        n_checks++;
        if (parity_err !== 1'b1 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad_hold: got perr %b v%b expected perr 1 v0", parity_err, key_valid);
        end
        issue_start(KEY_A);
        n_checks++;
        if (parity_err !== 1'b0 || key_valid !== 1'b1 || round_key !== k_tab[15]) begin
            n_fail++;
            $display("FAIL parity_good: got perr %b v%b key %h expected perr 0 v1 key %h",
                     parity_err, key_valid, round_key, k_tab[15]);
        end
        repeat (16) step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_done: got %b expected 1", done);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_ready_high();
        test_ready_toggle();
        test_start_ignored();
        test_start_on_last();
        test_reset_mid();
`ifdef DES_KS_PARITY_CHECK_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
